// File: rtl/border_fx_painter.sv
// Animated VGA border painter: edge-selectable border of any width with blink, colour-cycle and marching-stripe effects.
// One pixel-clock latency; animation state advances only on frame_start.
module border_fx_painter #(
  parameter int         H_ACTIVE        = 640,
  parameter int         V_ACTIVE        = 480,
  parameter int         BORDER_WIDTH    = 8,
  parameter int         FRAMES_PER_STEP = 8,
  parameter int         STRIPE_LOG2     = 3,
  parameter logic [5:0] RESET_COLOR     = 6'b111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       frame_start,
  input  logic [3:0] side_en,
  input  logic [1:0] mode,
  input  logic [5:0] base_color,
  output logic       in_border,
  output logic [5:0] color
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CYCLE  = 2'd2,
    MODE_MARCH  = 2'd3
  } mode_t;

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

  // Geometry held one bit wider than the position inputs so limits up to 2^N still compare correctly.
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] H_BW    = 11'(BORDER_WIDTH);
  localparam logic [10:0] H_RIGHT = 11'(H_ACTIVE - BORDER_WIDTH);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_BW    = 10'(BORDER_WIDTH);
  localparam logic [9:0]  V_BOT   = 10'(V_ACTIVE - BORDER_WIDTH);

  logic [FC_W-1:0] frame_cnt;
  logic [5:0]      step_cnt;
  mode_t           shadow_mode;
  logic [5:0]      shadow_color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      step_cnt     <= '0;
      shadow_mode  <= MODE_STATIC;
      shadow_color <= RESET_COLOR;
    end else if (frame_start) begin
      shadow_mode  <= mode_t'(mode);
      shadow_color <= base_color;
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        step_cnt  <= step_cnt + 6'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [10:0] h_ext;
  logic [9:0]  v_ext;
  logic        active;
  logic        region;
  logic        march_odd;
  logic        nxt_border;
  logic [5:0]  nxt_color;

  always_comb begin
    h_ext      = {1'b0, hpos};
    v_ext      = {1'b0, vpos};
    active     = (h_ext < H_ACT) && (v_ext < V_ACT);
    region     = active && ((side_en[0] && (v_ext <  V_BW))  ||
                            (side_en[1] && (v_ext >= V_BOT)) ||
                            (side_en[2] && (h_ext <  H_BW))  ||
                            (side_en[3] && (h_ext >= H_RIGHT)));
    // Only the parity of the stripe index matters, and the LSB of a sum is the XOR of the operand LSBs.
    march_odd  = 1'((({1'b0, hpos} + {2'b0, vpos}) >> STRIPE_LOG2)) ^ step_cnt[0];
    nxt_border = region;
    nxt_color  = shadow_color;
    case (shadow_mode)
      MODE_BLINK:  nxt_border = region && !step_cnt[0];
      MODE_CYCLE:  nxt_color  = shadow_color + step_cnt;
      MODE_MARCH:  nxt_color  = march_odd ? ~shadow_color : shadow_color;
      default:     nxt_color  = shadow_color;
    endcase
    if (!nxt_border) begin
      nxt_color = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_border <= 1'b0;
      color     <= 6'd0;
    end else begin
      in_border <= nxt_border;
      color     <= nxt_color;
    end
  end

endmodule
